// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin arbiter sharing one block-memory controller between I and D caches
//
// Purpose:
//   Grants the block-memory controller to one cache port at a time. The
//   winner's request becomes a single-cycle start pulse (m_enable) carrying
//   a latched copy of its address, direction and operation size. While the
//   block is in flight, write data, termination strobe and all controller
//   status are steered between the owner and the controller. After the
//   controller reports m_finished, one guard cycle is left idle before the
//   next start, so the controller can return to its ready state.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   i_req / d_req                   per-port request, held until finished
//   i_addr / d_addr                 per-port start address
//   i_rw / d_rw                     per-port direction (1 = write)
//   i_op_size / d_op_size           per-port size (0 = block, 1 = user-terminated)
//   i_finishes_op / d_finishes_op   per-port termination strobe
//   i_data_write / d_data_write     per-port write data
//   i_grant / d_grant               port owns the controller (registered)
//   i_data_write_req / d_...        routed write-data request
//   i_data_read / d_data_read       routed read data
//   i_data_read_valid / d_...       routed read valid
//   i_finished / d_finished         routed finished pulse
//   m_enable                        controller start pulse (registered, 1 cycle)
//   m_addr, m_rw, m_op_size         latched transaction attributes (registered)
//   m_finishes_op, m_data_write     owner's strobe / data while busy
//   m_data_write_req                controller write-data request
//   m_data_read, m_data_read_valid  controller read data / valid
//   m_finished                      controller finished pulse

module bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rw,
  input  logic                  i_op_size,
  input  logic                  i_finishes_op,
  input  logic [DATA_WIDTH-1:0] i_data_write,
  output logic                  i_grant,
  output logic                  i_data_write_req,
  output logic [DATA_WIDTH-1:0] i_data_read,
  output logic                  i_data_read_valid,
  output logic                  i_finished,

  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_rw,
  input  logic                  d_op_size,
  input  logic                  d_finishes_op,
  input  logic [DATA_WIDTH-1:0] d_data_write,
  output logic                  d_grant,
  output logic                  d_data_write_req,
  output logic [DATA_WIDTH-1:0] d_data_read,
  output logic                  d_data_read_valid,
  output logic                  d_finished,

  output logic                  m_enable,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_rw,
  output logic                  m_op_size,
  output logic                  m_finishes_op,
  output logic [DATA_WIDTH-1:0] m_data_write,
  input  logic                  m_data_write_req,
  input  logic [DATA_WIDTH-1:0] m_data_read,
  input  logic                  m_data_read_valid,
  input  logic                  m_finished
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Owner encoding: 0 = I, 1 = D. The value is only meaningful in ISSUE and
  // BUSY; every routing path below is qualified by the state, which is how
  // "no owner" is represented without a separate valid bit.
  logic r_owner_d;
  logic r_rr_last_d;

  logic w_start;
  logic w_done;
  logic w_win_d;
  logic w_busy;
  logic w_route_i;
  logic w_route_d;

  // Winner selection: a lone requester wins outright; on a tie the port
  // that did not finish last goes first.
  assign w_win_d = (i_req && d_req) ? ~r_rr_last_d : d_req;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        // A requester dropping req here is deliberately not observed; only
        // the controller can end a transaction once it has started.
        if (m_finished) begin
          w_done      = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_rr_last_d <= 1'b1;
      i_grant     <= 1'b0;
      d_grant     <= 1'b0;
      m_enable    <= 1'b0;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_op_size   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // The start pulse exists only for the single ISSUE cycle.
      m_enable <= w_start;
      if (w_start) begin
        r_owner_d <= w_win_d;
        i_grant   <= ~w_win_d;
        d_grant   <= w_win_d;
        // Attributes are captured once here and held until the next start,
        // so requester-side changes after the grant cannot disturb the block.
        m_addr    <= w_win_d ? d_addr    : i_addr;
        m_rw      <= w_win_d ? d_rw      : i_rw;
        m_op_size <= w_win_d ? d_op_size : i_op_size;
      end
      if (w_done) begin
        r_rr_last_d <= r_owner_d;
        i_grant     <= 1'b0;
        d_grant     <= 1'b0;
      end
    end
  end

  // Data/status steering is live only in BUSY, so a stray m_finished or
  // read-valid in any other state never reaches a cache.
  assign w_busy    = (r_state == S_BUSY);
  assign w_route_i = w_busy && !r_owner_d;
  assign w_route_d = w_busy &&  r_owner_d;

  assign m_data_write  = w_route_d ? d_data_write  :
                         w_route_i ? i_data_write  : '0;
  assign m_finishes_op = w_route_d ? d_finishes_op :
                         w_route_i ? i_finishes_op : 1'b0;

  assign i_data_write_req  = w_route_i && m_data_write_req;
  assign i_data_read_valid = w_route_i && m_data_read_valid;
  assign i_finished        = w_route_i && m_finished;
  assign i_data_read       = w_route_i ? m_data_read : '0;

  assign d_data_write_req  = w_route_d && m_data_write_req;
  assign d_data_read_valid = w_route_d && m_data_read_valid;
  assign d_finished        = w_route_d && m_finished;
  assign d_data_read       = w_route_d ? m_data_read : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter against a transaction-level model

module tb_bram_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          i_req = 0, d_req = 0;
  logic [AW-1:0] i_addr = 0, d_addr = 0;
  logic          i_rw = 0, d_rw = 0, i_op_size = 0, d_op_size = 0;
  logic          i_finishes_op = 0, d_finishes_op = 0;
  logic [DW-1:0] i_data_write = 0, d_data_write = 0;
  logic          i_grant, d_grant, i_data_write_req, d_data_write_req;
  logic [DW-1:0] i_data_read, d_data_read;
  logic          i_data_read_valid, d_data_read_valid, i_finished, d_finished;
  logic          m_enable, m_rw, m_op_size, m_finishes_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_write;
  logic          m_data_write_req = 0, m_data_read_valid = 0, m_finished = 0;
  logic [DW-1:0] m_data_read = 0;

  int total = 0;
  int bad   = 0;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rw(i_rw), .i_op_size(i_op_size),
    .i_finishes_op(i_finishes_op), .i_data_write(i_data_write),
    .i_grant(i_grant), .i_data_write_req(i_data_write_req), .i_data_read(i_data_read),
    .i_data_read_valid(i_data_read_valid), .i_finished(i_finished),
    .d_req(d_req), .d_addr(d_addr), .d_rw(d_rw), .d_op_size(d_op_size),
    .d_finishes_op(d_finishes_op), .d_data_write(d_data_write),
    .d_grant(d_grant), .d_data_write_req(d_data_write_req), .d_data_read(d_data_read),
    .d_data_read_valid(d_data_read_valid), .d_finished(d_finished),
    .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_op_size(m_op_size),
    .m_finishes_op(m_finishes_op), .m_data_write(m_data_write),
    .m_data_write_req(m_data_write_req), .m_data_read(m_data_read),
    .m_data_read_valid(m_data_read_valid), .m_finished(m_finished)
  );

  always #5 clk = ~clk;

  // Transaction-level model: who holds the controller (-1 = nobody), whether
  // this is the start cycle, how many idle guard cycles remain, and who
  // finished last.
  int            mdl_owner = -1;
  logic          mdl_start = 1'b0;
  int            mdl_gap   = 0;
  int            mdl_last  = 1;
  logic [AW-1:0] mdl_addr  = '0;
  logic          mdl_rw    = 1'b0;
  logic          mdl_size  = 1'b0;

  function automatic int pick(input logic ir, input logic dr, input int last);
    if (ir && dr) return (last == 0) ? 1 : 0;
    return dr ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_owner <= -1;
      mdl_start <= 1'b0;
      mdl_gap   <= 0;
      mdl_last  <= 1;
      mdl_addr  <= '0;
      mdl_rw    <= 1'b0;
      mdl_size  <= 1'b0;
    end else if (mdl_owner < 0) begin
      if (mdl_gap > 0) begin
        mdl_gap <= mdl_gap - 1;
      end else if (i_req || d_req) begin
        mdl_owner <= pick(i_req, d_req, mdl_last);
        mdl_start <= 1'b1;
        mdl_addr  <= (pick(i_req, d_req, mdl_last) == 1) ? d_addr    : i_addr;
        mdl_rw    <= (pick(i_req, d_req, mdl_last) == 1) ? d_rw      : i_rw;
        mdl_size  <= (pick(i_req, d_req, mdl_last) == 1) ? d_op_size : i_op_size;
      end
    end else if (mdl_start) begin
      mdl_start <= 1'b0;
    end else if (m_finished) begin
      mdl_last  <= mdl_owner;
      mdl_owner <= -1;
      mdl_gap   <= 1;
    end
  end

  logic          e_xfer_i, e_xfer_d;
  logic [DW-1:0] e_mwd;
  logic          e_mfo;
  assign e_xfer_i = (mdl_owner == 0) && !mdl_start;
  assign e_xfer_d = (mdl_owner == 1) && !mdl_start;
  assign e_mwd    = e_xfer_i ? i_data_write  : (e_xfer_d ? d_data_write  : '0);
  assign e_mfo    = e_xfer_i ? i_finishes_op : (e_xfer_d ? d_finishes_op : 1'b0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("i_grant", i_grant, mdl_owner == 0);
    chk("d_grant", d_grant, mdl_owner == 1);
    chk("m_enable", m_enable, mdl_start);
    chk("m_addr", m_addr, mdl_addr);
    chk("m_rw", m_rw, mdl_rw);
    chk("m_op_size", m_op_size, mdl_size);
    chk("m_data_write", m_data_write, e_mwd);
    chk("m_finishes_op", m_finishes_op, e_mfo);
    chk("i_data_write_req", i_data_write_req, e_xfer_i && m_data_write_req);
    chk("d_data_write_req", d_data_write_req, e_xfer_d && m_data_write_req);
    chk("i_data_read_valid", i_data_read_valid, e_xfer_i && m_data_read_valid);
    chk("d_data_read_valid", d_data_read_valid, e_xfer_d && m_data_read_valid);
    chk("i_finished", i_finished, e_xfer_i && m_finished);
    chk("d_finished", d_finished, e_xfer_d && m_finished);
    chk("i_data_read", i_data_read, e_xfer_i ? m_data_read : '0);
    chk("d_data_read", d_data_read, e_xfer_d ? m_data_read : '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int nvalid;
  int nwr;
  int nen;

  initial begin
    #1 rst = 1'b1;
    tick();
    #1;
    chk("rst_i_grant", i_grant, 0);
    chk("rst_d_grant", d_grant, 0);
    chk("rst_m_enable", m_enable, 0);
    chk("rst_m_addr", m_addr, 0);
    tick();
    rst = 1'b0;

    // I-only read of a whole block
    i_req = 1; i_addr = 16'h0120; i_rw = 0; i_op_size = 0;
    tick(); #1;
    chk("t1_m_enable", m_enable, 1);
    chk("t1_m_addr", m_addr, 16'h0120);
    chk("t1_m_rw", m_rw, 0);
    chk("t1_i_grant", i_grant, 1);
    i_addr = 16'h3333; i_rw = 1;
    tick(); #1;
    chk("t1_enable_one_cycle", m_enable, 0);
    nvalid = 0;
    for (int k = 0; k < 32; k++) begin
      m_data_read_valid = 1; m_data_read = $urandom;
      #1;
      if (i_data_read_valid) nvalid++;
      chk("t1_d_valid_quiet", d_data_read_valid, 0);
      tick();
    end
    m_data_read_valid = 0;
    chk("t1_valid_count", nvalid, 32);
    chk("t1_addr_stable", m_addr, 16'h0120);
    m_finished = 1; #1;
    chk("t1_i_finished", i_finished, 1);
    chk("t1_d_finished", d_finished, 0);
    tick();
    m_finished = 0; i_req = 0; #1;
    chk("t1_grant_dropped", i_grant, 0);
    tick(); tick();

    // Tie after reset: I first, D starts two edges after I's finish edge
    do_reset();
    i_addr = 16'h0200; i_rw = 0;
    d_addr = 16'h0456; d_rw = 1;
    i_req = 1; d_req = 1;
    tick(); #1;
    chk("t2_i_first", i_grant, 1);
    chk("t2_d_held", d_grant, 0);
    chk("t2_m_addr", m_addr, 16'h0200);
    tick(); tick();
    m_finished = 1;
    tick();
    m_finished = 0; i_req = 0; #1;
    chk("t2_release_no_en", m_enable, 0);
    tick();
    i_req = 1; #1;
    chk("t2_idle_no_en", m_enable, 0);
    chk("t2_idle_no_grant", d_grant, 0);
    tick(); #1;
    chk("t2_d_enable", m_enable, 1);
    chk("t2_tie_to_d", d_grant, 1);
    chk("t2_m_addr_d", m_addr, 16'h0456);
    chk("t2_m_rw_d", m_rw, 1);
    tick();
    m_finished = 1;
    tick();
    m_finished = 0; d_req = 0;
    tick(); tick(); #1;
    chk("t2_i_again", i_grant, 1);
    tick();
    m_finished = 1;
    tick();
    m_finished = 0; i_req = 0;
    tick(); tick();

    // D user-terminated write
    d_req = 1; d_rw = 1; d_op_size = 1; d_addr = 16'h0777;
    tick(); #1;
    chk("t3_d_grant", d_grant, 1);
    chk("t3_op_size", m_op_size, 1);
    tick();
    nwr = 0;
    for (int k = 0; k < 20 && nwr < 5; k++) begin
      m_data_write_req = (k % 2 == 0);
      d_data_write = $urandom;
      if (m_data_write_req) nwr++;
      d_finishes_op = m_data_write_req && (nwr == 5);
      #1;
      if (d_finishes_op) begin
        chk("t3_m_finishes_op", m_finishes_op, 1);
        chk("t3_m_data_write", m_data_write, d_data_write);
      end
      tick();
    end
    m_data_write_req = 0; d_finishes_op = 0;
    m_finished = 1; #1;
    chk("t3_d_finished", d_finished, 1);
    tick();
    m_finished = 0; d_req = 0;
    tick(); tick();

    // Owner drops req mid-block; tie resolves to I because D finished last
    i_req = 1; d_req = 1; i_addr = 16'h0abc;
    tick(); #1;
    chk("t4_tie_to_i", i_grant, 1);
    d_req = 0;
    tick();
    i_req = 0;
    tick(); tick(); #1;
    chk("t4_grant_held", i_grant, 1);
    m_finished = 1; #1;
    chk("t4_finished_routed", i_finished, 1);
    tick();
    m_finished = 0;
    nen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (m_enable) nen++;
    end
    chk("t4_no_second_enable", nen, 0);

    // Asynchronous reset mid-read, pending D request afterwards
    i_req = 1; i_addr = 16'h0100;
    tick(); tick();
    m_data_read_valid = 1; m_data_read = 32'hdeadbeef; d_req = 1;
    #2 rst = 1'b1;
    #1;
    chk("t5_i_grant", i_grant, 0);
    chk("t5_m_enable", m_enable, 0);
    chk("t5_m_addr", m_addr, 0);
    chk("t5_i_valid", i_data_read_valid, 0);
    chk("t5_i_data", i_data_read, 0);
    i_req = 0; m_data_read_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    tick(); #1;
    chk("t5_d_enable", m_enable, 1);
    chk("t5_d_grant", d_grant, 1);
    tick();
    m_finished = 1;
    tick();
    m_finished = 0; d_req = 0;
    tick(); tick();

    // Spurious m_finished while idle
    m_finished = 1; #1;
    chk("t6_i_finished", i_finished, 0);
    chk("t6_d_finished", d_finished, 0);
    tick(); #1;
    chk("t6_i_grant", i_grant, 0);
    chk("t6_d_grant", d_grant, 0);
    m_finished = 0;
    tick();

    // Randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      i_req = ($urandom_range(0, 3) != 0);
      d_req = ($urandom_range(0, 3) != 0);
      i_addr = AW'($urandom); d_addr = AW'($urandom);
      i_rw = 1'($urandom); d_rw = 1'($urandom);
      i_op_size = 1'($urandom); d_op_size = 1'($urandom);
      i_finishes_op = 1'($urandom); d_finishes_op = 1'($urandom);
      i_data_write = $urandom; d_data_write = $urandom;
      m_data_write_req = 1'($urandom); m_data_read_valid = 1'($urandom);
      m_data_read = $urandom;
      m_finished = ($urandom_range(0, 5) == 0);
      if (k == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
